// File: rtl/memoria_datos_p_if.sv
// Bus bundle for memoria_datos_p: write port, dual read port, status flags.
interface memoria_datos_p_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 3
);
  logic              init_i;
  logic              we_i;
  logic [ADDR_W-1:0] waddr_i;
  logic [DATA_W-1:0] wdata_i;
  logic              re_i;
  logic [ADDR_W-1:0] raddr_a_i;
  logic [ADDR_W-1:0] raddr_b_i;
  logic [DATA_W-1:0] dato_a_o;
  logic [DATA_W-1:0] dato_b_o;
  logic              valid_o;
  logic              busy_o;

  modport master (
    output init_i, we_i, waddr_i, wdata_i, re_i, raddr_a_i, raddr_b_i,
    input  dato_a_o, dato_b_o, valid_o, busy_o
  );

  modport slave (
    input  init_i, we_i, waddr_i, wdata_i, re_i, raddr_a_i, raddr_b_i,
    output dato_a_o, dato_b_o, valid_o, busy_o
  );
endinterface

// File: rtl/memoria_datos_p.sv
// Parametrised data memory: one write port, two registered read ports,
// and a fill sequencer that (re)initialises the array after reset or init_i.
module memoria_datos_p #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned ADDR_W    = 3,
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned INIT_MODE = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  memoria_datos_p_if.slave  bus
);
  typedef enum logic {ST_INIT, ST_READY} state_e;

  localparam int unsigned     CNT_W   = ADDR_W + 1;
  localparam logic [ADDR_W:0] DEPTH_L = CNT_W'(DEPTH);
  localparam logic [ADDR_W:0] LAST_L  = CNT_W'(DEPTH - 1);

  state_e            state_q, state_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] dato_a_q, dato_a_d;
  logic [DATA_W-1:0] dato_b_q, dato_b_d;
  logic              valid_q, valid_d;

  logic              rd_en, wr_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] fill_val;

  function automatic logic in_range(input logic [ADDR_W-1:0] addr);
    return {1'b0, addr} < DEPTH_L;
  endfunction

  // Write-first: a same-cycle write to the read address bypasses the array.
  function automatic logic [DATA_W-1:0] read_word(input logic [ADDR_W-1:0] addr);
    if (wr_en && (bus.waddr_i == addr)) return bus.wdata_i;
    else if (in_range(addr))            return mem_q[addr];
    else                                return '0;
  endfunction

  assign fill_val = (INIT_MODE == 1) ? DATA_W'(cnt_q) : '0;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rd_en     = 1'b0;
    wr_en     = 1'b0;
    mem_we    = 1'b0;
    mem_waddr = bus.waddr_i;
    mem_wdata = bus.wdata_i;
    unique case (state_q)
      ST_INIT: begin
        mem_we    = 1'b1;
        mem_waddr = cnt_q[ADDR_W-1:0];
        mem_wdata = fill_val;
        if (cnt_q == LAST_L) begin
          state_d = ST_READY;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_READY: begin
        if (bus.init_i) begin
          state_d = ST_INIT;
          cnt_d   = '0;
        end else begin
          rd_en  = bus.re_i;
          wr_en  = bus.we_i && in_range(bus.waddr_i);
          mem_we = wr_en;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    valid_d  = rd_en;
    dato_a_d = dato_a_q;
    dato_b_d = dato_b_q;
    if (rd_en) begin
      dato_a_d = read_word(bus.raddr_a_i);
      dato_b_d = read_word(bus.raddr_b_i);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= ST_INIT;
      cnt_q    <= '0;
      dato_a_q <= '0;
      dato_b_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      dato_a_q <= dato_a_d;
      dato_b_q <= dato_b_d;
      valid_q  <= valid_d;
    end
  end

  // Array has no reset: the fill sequence establishes its contents.
  always_ff @(posedge clk_i) begin
    if (!rst_i && mem_we) mem_q[mem_waddr] <= mem_wdata;
  end

  assign bus.dato_a_o = dato_a_q;
  assign bus.dato_b_o = dato_b_q;
  assign bus.valid_o  = valid_q;
  assign bus.busy_o   = rst_i || (state_q == ST_INIT);
endmodule

// File: tb/tb_memoria_datos_p.sv
// Directed bench for memoria_datos_p: default 8-word instance plus a 6-word
// instance for out-of-range behaviour.
module tb_memoria_datos_p;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  memoria_datos_p_if #(.DATA_W(32), .ADDR_W(3)) bus8 ();
  memoria_datos_p_if #(.DATA_W(32), .ADDR_W(3)) bus6 ();

  memoria_datos_p #(.DATA_W(32), .ADDR_W(3), .DEPTH(8), .INIT_MODE(1)) u_dut8 (
    .clk_i (clk), .rst_i (rst), .bus (bus8.slave)
  );
  memoria_datos_p #(.DATA_W(32), .ADDR_W(3), .DEPTH(6), .INIT_MODE(1)) u_dut6 (
    .clk_i (clk), .rst_i (rst), .bus (bus6.slave)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Count cycles each instance reports busy, bounded so a stuck FSM still ends.
  task automatic wait_ready(output int n8, output int n6);
    int guard = 0;
    n8 = 0;
    n6 = 0;
    while ((bus8.busy_o || bus6.busy_o) && guard < 20) begin
      if (bus8.busy_o) n8++;
      if (bus6.busy_o) n6++;
      guard++;
      tick();
    end
  endtask

  task automatic idle8();
    bus8.init_i = 1'b0; bus8.we_i = 1'b0; bus8.re_i = 1'b0;
  endtask

  task automatic read8(input logic [2:0] a, input logic [2:0] b);
    bus8.re_i = 1'b1; bus8.raddr_a_i = a; bus8.raddr_b_i = b;
    tick();
    bus8.re_i = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n8, n6, nvalid;
    bus8.init_i = 0; bus8.we_i = 0; bus8.waddr_i = '0; bus8.wdata_i = '0;
    bus8.re_i = 0; bus8.raddr_a_i = '0; bus8.raddr_b_i = '0;
    bus6.init_i = 0; bus6.we_i = 0; bus6.waddr_i = '0; bus6.wdata_i = '0;
    bus6.re_i = 0; bus6.raddr_a_i = '0; bus6.raddr_b_i = '0;

    // Test 1: reset, fill timing, first read
    tick();
    check("rst_busy", 32'(bus8.busy_o), 32'd1);
    check("rst_valid", 32'(bus8.valid_o), 32'd0);
    check("rst_dato_a", bus8.dato_a_o, 32'd0);
    check("rst_dato_b", bus8.dato_b_o, 32'd0);
    tick();
    rst = 1'b0;
    wait_ready(n8, n6);
    check("fill_cycles8", 32'(n8), 32'd8);
    check("fill_cycles6", 32'(n6), 32'd6);
    read8(3'd5, 3'd0);
    check("t1_a", bus8.dato_a_o, 32'd5);
    check("t1_b", bus8.dato_b_o, 32'd0);
    check("t1_valid", 32'(bus8.valid_o), 32'd1);
    tick();
    check("t1_valid_drop", 32'(bus8.valid_o), 32'd0);
    check("t1_hold_a", bus8.dato_a_o, 32'd5);

    // Test 2: write then read
    bus8.we_i = 1'b1; bus8.waddr_i = 3'd5; bus8.wdata_i = 32'hFFFF_FFFB;
    tick();
    bus8.we_i = 1'b0;
    read8(3'd5, 3'd1);
    check("t2_a", bus8.dato_a_o, 32'hFFFF_FFFB);
    check("t2_b", bus8.dato_b_o, 32'd1);
    check("t2_valid", 32'(bus8.valid_o), 32'd1);

    // Test 3: read-during-write, both ports same address
    bus8.we_i = 1'b1; bus8.waddr_i = 3'd2; bus8.wdata_i = 32'd10;
    read8(3'd2, 3'd2);
    bus8.we_i = 1'b0;
    check("t3_a_wf", bus8.dato_a_o, 32'd10);
    check("t3_b_wf", bus8.dato_b_o, 32'd10);
    read8(3'd2, 3'd7);
    check("t3_stored", bus8.dato_a_o, 32'd10);
    check("t3_b7", bus8.dato_b_o, 32'd7);

    // Back-to-back reads: valid stays high, data advances
    bus8.re_i = 1'b1; bus8.raddr_a_i = 3'd0; bus8.raddr_b_i = 3'd1;
    tick();
    check("b2b_a0", bus8.dato_a_o, 32'd0);
    check("b2b_b0", bus8.dato_b_o, 32'd1);
    check("b2b_v0", 32'(bus8.valid_o), 32'd1);
    bus8.raddr_a_i = 3'd3; bus8.raddr_b_i = 3'd4;
    tick();
    bus8.re_i = 1'b0;
    check("b2b_a1", bus8.dato_a_o, 32'd3);
    check("b2b_b1", bus8.dato_b_o, 32'd4);
    check("b2b_v1", 32'(bus8.valid_o), 32'd1);

    // Test 4: init pulse, writes and reads ignored while busy, refill restores
    bus8.init_i = 1'b1;
    tick();
    bus8.init_i = 1'b0;
    bus8.we_i = 1'b1; bus8.waddr_i = 3'd5; bus8.wdata_i = 32'd7;
    bus8.re_i = 1'b1; bus8.raddr_a_i = 3'd5; bus8.raddr_b_i = 3'd5;
    nvalid = 0;
    n8 = 0;
    for (int i = 0; i < 20 && bus8.busy_o; i++) begin
      n8++;
      if (bus8.valid_o) nvalid++;
      tick();
    end
    idle8();
    check("t4_busy", 32'(n8), 32'd8);
    check("t4_no_valid", 32'(nvalid), 32'd0);
    read8(3'd5, 3'd2);
    check("t4_a5", bus8.dato_a_o, 32'd5);
    check("t4_b2", bus8.dato_b_o, 32'd2);

    // Test 5: reset mid-fill
    bus8.init_i = 1'b1;
    tick();
    bus8.init_i = 1'b0;
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    check("t5_a", bus8.dato_a_o, 32'd0);
    check("t5_b", bus8.dato_b_o, 32'd0);
    check("t5_valid", 32'(bus8.valid_o), 32'd0);
    check("t5_busy", 32'(bus8.busy_o), 32'd1);
    rst = 1'b0;
    wait_ready(n8, n6);
    check("t5_fill8", 32'(n8), 32'd8);
    read8(3'd7, 3'd6);
    check("t5_a7", bus8.dato_a_o, 32'd7);
    check("t5_b6", bus8.dato_b_o, 32'd6);

    // init, write and read together: init wins
    bus8.init_i = 1'b1; bus8.we_i = 1'b1; bus8.waddr_i = 3'd1; bus8.wdata_i = 32'd99;
    bus8.re_i = 1'b1; bus8.raddr_a_i = 3'd1; bus8.raddr_b_i = 3'd1;
    tick();
    idle8();
    check("prio_valid", 32'(bus8.valid_o), 32'd0);
    check("prio_busy", 32'(bus8.busy_o), 32'd1);
    check("prio_hold", bus8.dato_a_o, 32'd7);
    wait_ready(n8, n6);
    check("prio_fill", 32'(n8), 32'd8);
    read8(3'd1, 3'd0);
    check("prio_a1", bus8.dato_a_o, 32'd1);

    // Test 6: DEPTH=6 out-of-range write and read
    bus6.we_i = 1'b1; bus6.waddr_i = 3'd7; bus6.wdata_i = 32'hAA;
    tick();
    bus6.we_i = 1'b0;
    bus6.re_i = 1'b1; bus6.raddr_a_i = 3'd7; bus6.raddr_b_i = 3'd5;
    tick();
    bus6.re_i = 1'b0;
    check("t6_a_oor", bus6.dato_a_o, 32'd0);
    check("t6_b5", bus6.dato_b_o, 32'd5);
    check("t6_valid", 32'(bus6.valid_o), 32'd1);
    for (int k = 0; k < 6; k++) begin
      bus6.re_i = 1'b1; bus6.raddr_a_i = 3'(k); bus6.raddr_b_i = 3'd6;
      tick();
      bus6.re_i = 1'b0;
      check($sformatf("t6_word%0d", k), bus6.dato_a_o, 32'(k));
      check($sformatf("t6_oor6_%0d", k), bus6.dato_b_o, 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
